// File: rtl/fir3_deconv.sv
// Inverse filter for a 3-tap FIR: x[n] = (y[n] - R2*x[n-1] - R3*x[n-2]) >>> R1_SHIFT.
// One shared registered 8x8 multiplier, sequenced over five states per sample.
module fir3_deconv #(
  parameter int                 IN_W     = 18,
  parameter int                 OUT_W    = 8,
  parameter int                 R1_SHIFT = 1,
  parameter logic signed [7:0]  R2       = -8'sd4,
  parameter logic signed [7:0]  R3       = 8'sd7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    in_drop
);

  localparam int S_W  = IN_W + 2;
  localparam int P_W  = OUT_W + 8;
  localparam int Q_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int Q_MIN = -(2 ** (OUT_W - 1));

  typedef enum logic [2:0] {
    IDLE,
    MUL2,
    MUL3,
    SUM,
    OUT
  } state_t;

  state_t                   state_q, state_d;
  logic signed [IN_W-1:0]   yv_q, yv_d;
  logic signed [OUT_W-1:0]  x1_q, x1_d;
  logic signed [OUT_W-1:0]  x2_q, x2_d;
  logic signed [P_W-1:0]    p2_q, p2_d;
  logic signed [P_W-1:0]    prod_q, prod_d;
  logic signed [S_W-1:0]    s_q, s_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_sat_q, out_sat_d;
  logic                     in_drop_q, in_drop_d;

  logic signed [OUT_W-1:0]  mul_a;
  logic signed [7:0]        mul_b;
  logic signed [S_W-1:0]    q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign in_drop   = in_drop_q;

  assign q = s_q >>> R1_SHIFT;

  always_comb begin
    state_d     = state_q;
    yv_d        = yv_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    p2_d        = p2_q;
    s_d         = s_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = 1'b0;
    in_drop_d   = in_drop_q | (in_valid & ~in_ready);
    mul_a       = '0;
    mul_b       = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          yv_d    = in_data;
          state_d = MUL2;
        end
      end
      MUL2: begin
        mul_a   = x1_q;
        mul_b   = R2;
        state_d = MUL3;
      end
      MUL3: begin
        mul_a   = x2_q;
        mul_b   = R3;
        p2_d    = prod_q;
        state_d = SUM;
      end
      SUM: begin
        // widened by two bits so the double subtraction cannot wrap
        s_d     = S_W'(yv_q) - S_W'(p2_q) - S_W'(prod_q);
        state_d = OUT;
      end
      OUT: begin
        if (q > S_W'(Q_MAX)) begin
          out_data_d = OUT_W'(Q_MAX);
          out_sat_d  = 1'b1;
        end else if (q < S_W'(Q_MIN)) begin
          out_data_d = OUT_W'(Q_MIN);
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = OUT_W'(q);
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        x2_d        = x1_q;
        x1_d        = out_data_d;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    prod_d = mul_a * mul_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      yv_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      p2_q        <= '0;
      prod_q      <= '0;
      s_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      in_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      yv_q        <= yv_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      p2_q        <= p2_d;
      prod_q      <= prod_d;
      s_q         <= s_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      in_drop_q   <= in_drop_d;
    end
  end

endmodule
